// File: rtl/lvds_rx_pkg.sv
// ============================================================================
// Module      : lvds_rx_pkg
// Description : Shared types and defaults for the 6x LVDS receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lvds_rx_pkg;

    localparam int              c_default_word_w        = 6;
    localparam logic [5:0]      c_default_frame_pattern = 6'b111000;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_CHECK     = 3'd1,
        ST_SLIP      = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_ALIGNED   = 3'd4,
        ST_FAIL      = 3'd5
    } align_state_t;

endpackage

`default_nettype wire

// File: rtl/lvds_frame_align_sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/lvds_frame_align.sv
// ============================================================================
// Module      : lvds_frame_align
// Description : Bitslip-driven frame alignment controller for the LVDS RX.
//               Optional LVDS_FRAME_ALIGN_STATS_EN adds the err_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvds_frame_align
    import lvds_rx_pkg::*;
#(
    parameter int                WORD_W        = c_default_word_w,
    parameter int                NUM_LANES     = 2,
    parameter logic [WORD_W-1:0] FRAME_PATTERN = c_default_frame_pattern,
    parameter int                MATCH_COUNT   = 16,
    parameter int                LOSS_COUNT    = 4,
    parameter int                SETTLE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pll_locked,
    input  logic                          restart,
    input  logic [WORD_W-1:0]             frame_word,
    input  logic [NUM_LANES*WORD_W-1:0]   data_words,
    output logic                          bitslip,
    output logic                          aligned,
    output logic                          align_fail,
    output logic [$clog2(WORD_W+1)-1:0]   slip_count,
    output logic [NUM_LANES*WORD_W-1:0]   data_out,
    output logic                          data_valid
`ifdef LVDS_FRAME_ALIGN_STATS_EN
    ,
    output logic [15:0]                   err_count
`endif
);

    localparam int SW = $clog2(WORD_W + 1);
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SW-1:0] c_slip_max    = SW'(WORD_W);
    localparam logic [MW-1:0] c_match_max   = MW'(MATCH_COUNT);
    localparam logic [MW-1:0] c_match_last  = MW'(MATCH_COUNT - 1);
    localparam logic [LW-1:0] c_loss_max    = LW'(LOSS_COUNT);
    localparam logic [LW-1:0] c_loss_last   = LW'(LOSS_COUNT - 1);
    localparam logic [TW-1:0] c_settle_max  = TW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] c_settle_last = TW'(SETTLE_CYCLES - 1);

    logic                        w_lock;
    logic                        w_match;
    align_state_t                r_state;
    align_state_t                w_state_next;
    logic [SW-1:0]               r_slip_cnt;
    logic [MW-1:0]               r_match_cnt;
    logic [LW-1:0]               r_loss_cnt;
    logic [TW-1:0]               r_settle_cnt;
    logic                        r_bitslip;
    logic                        r_aligned;
    logic                        r_align_fail;
    logic                        r_data_valid;
    logic [NUM_LANES*WORD_W-1:0] r_data_out;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_lock)
    );

    assign w_match = (frame_word == FRAME_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_LOCK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Loss of lock overrides every other transition, restart included.
    always_comb begin
        w_state_next = r_state;
        if (!w_lock) begin
            w_state_next = ST_WAIT_LOCK;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: w_state_next = ST_CHECK;
                ST_CHECK: begin
                    if (w_match) begin
                        if (r_match_cnt == c_match_last) w_state_next = ST_ALIGNED;
                    end else if (r_slip_cnt < c_slip_max) begin
                        w_state_next = ST_SLIP;
                    end else begin
                        w_state_next = ST_FAIL;
                    end
                end
                ST_SLIP:    w_state_next = ST_SETTLE;
                ST_SETTLE:  if (r_settle_cnt == c_settle_last) w_state_next = ST_CHECK;
                ST_ALIGNED: if (!w_match && r_loss_cnt == c_loss_last) w_state_next = ST_CHECK;
                ST_FAIL:    if (restart) w_state_next = ST_CHECK;
                default:    w_state_next = ST_WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slip_cnt   <= '0;
            r_match_cnt  <= '0;
            r_loss_cnt   <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (r_state == ST_CHECK && w_match && w_lock) begin
                if (r_match_cnt != c_match_max) r_match_cnt <= r_match_cnt + 1'b1;
            end else begin
                r_match_cnt <= '0;
            end

            if (r_state == ST_ALIGNED && !w_match && w_lock) begin
                if (r_loss_cnt != c_loss_max) r_loss_cnt <= r_loss_cnt + 1'b1;
            end else begin
                r_loss_cnt <= '0;
            end

            if (r_state == ST_SETTLE && w_lock) begin
                if (r_settle_cnt != c_settle_max) r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end

            // Settle returns to CHECK keeping the count; loss and restart start a fresh search.
            if (w_state_next == ST_SLIP) begin
                if (r_slip_cnt != c_slip_max) r_slip_cnt <= r_slip_cnt + 1'b1;
            end else if (w_state_next == ST_WAIT_LOCK ||
                         (w_state_next == ST_CHECK &&
                          (r_state == ST_ALIGNED || r_state == ST_FAIL))) begin
                r_slip_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitslip    <= 1'b0;
            r_aligned    <= 1'b0;
            r_align_fail <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_bitslip    <= (w_state_next == ST_SLIP);
            r_aligned    <= w_lock && (r_state == ST_ALIGNED);
            r_data_valid <= w_lock && (r_state == ST_ALIGNED);
            r_align_fail <= (w_state_next == ST_FAIL);
            r_data_out   <= data_words;
        end
    end

`ifdef LVDS_FRAME_ALIGN_STATS_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_state_next == ST_WAIT_LOCK) begin
            r_err_cnt <= '0;
        end else if (r_state == ST_ALIGNED && !w_match && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

    assign bitslip    = r_bitslip;
    assign aligned    = r_aligned;
    assign align_fail = r_align_fail;
    assign slip_count = r_slip_cnt;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_lvds_frame_align.sv
// ============================================================================
// Module      : tb_lvds_frame_align
// Description : Self-checking bench for lvds_frame_align with a rotating
//               frame-lane model driven by the DUT bitslip output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lvds_frame_align;

    localparam logic [5:0] PAT = 6'b111000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked = 1'b0;
    logic        restart = 1'b0;
    logic [5:0]  frame_word;
    logic [11:0] data_words = 12'h000;
    logic        bitslip;
    logic        aligned;
    logic        align_fail;
    logic [2:0]  slip_count;
    logic [11:0] data_out;
    logic        data_valid;
`ifdef LVDS_FRAME_ALIGN_STATS_EN
    logic [15:0] err_count;
`endif

    int tests = 0;
    int fails = 0;

    // Deserializer model: the frame lane rotates right once per bitslip pulse.
    int         slips_seen = 0;
    int         slip_base = 0;
    int         cyc = 0;
    int         last_slip_cyc = 0;
    int         slip_gap = 0;
    logic [5:0] base = PAT;
    logic       bad = 1'b0;

    typedef struct {
        logic        bad;
        logic [11:0] data;
        logic        exp_al;
    } vec_t;
    vec_t vecs[10];

    function automatic logic [5:0] rotr(logic [5:0] v, int n);
        logic [5:0] r;
        r = v;
        for (int i = 0; i < (n % 6); i++) r = {r[0], r[5:1]};
        return r;
    endfunction

    assign frame_word = bad ? 6'b000000 : rotr(base, slips_seen - slip_base);

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bitslip) begin
            slips_seen    <= slips_seen + 1;
            slip_gap      <= cyc - last_slip_cyc;
            last_slip_cyc <= cyc;
        end
    end

    lvds_frame_align dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .frame_word (frame_word),
        .data_words (data_words),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .align_fail (align_fail),
        .slip_count (slip_count),
        .data_out   (data_out),
        .data_valid (data_valid)
`ifdef LVDS_FRAME_ALIGN_STATS_EN
        ,
        .err_count  (err_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        bad        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int snap;

        vecs[0] = '{1'b1, 12'h0A5, 1'b1};
        vecs[1] = '{1'b1, 12'hF0F, 1'b1};
        vecs[2] = '{1'b1, 12'h123, 1'b1};
        vecs[3] = '{1'b0, 12'hFFF, 1'b1};
        vecs[4] = '{1'b1, 12'h800, 1'b1};
        vecs[5] = '{1'b1, 12'h001, 1'b1};
        vecs[6] = '{1'b1, 12'h5A5, 1'b1};
        vecs[7] = '{1'b1, 12'hA5A, 1'b1};
        vecs[8] = '{1'b0, 12'h3C3, 1'b0};
        vecs[9] = '{1'b0, 12'hC3C, 1'b0};

        // Reset values
        data_words = 12'hABC;
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_bitslip", 32'(bitslip), 32'd0);
        check("reset_aligned", 32'(aligned), 32'd0);
        check("reset_align_fail", 32'(align_fail), 32'd0);
        check("reset_slip_count", 32'(slip_count), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_data_valid", 32'(data_valid), 32'd0);
`ifdef LVDS_FRAME_ALIGN_STATS_EN
        check("reset_err_count", 32'(err_count), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Already aligned frame: aligned exactly 20 edges after lock
        base = PAT;
        slip_base = slips_seen;
        pll_locked = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 19) check("align_not_early", 32'(aligned), 32'd0);
            if (k == 20) begin
                check("align_on_time", 32'(aligned), 32'd1);
                check("valid_on_time", 32'(data_valid), 32'd1);
            end
        end
        check("no_slips_aligned", 32'(slips_seen - slip_base), 32'd0);
        check("slip_count_zero", 32'(slip_count), 32'd0);

        // Pattern rotated by 2: two slips, settle gap of 10 cycles
        do_reset();
        base = 6'b100011;
        slip_base = slips_seen;
        pll_locked = 1'b1;
        for (int k = 0; k < 100 && !aligned; k++) tick();
        check("rot2_aligned", 32'(aligned), 32'd1);
        check("rot2_slips", 32'(slips_seen - slip_base), 32'd2);
        check("rot2_slip_count", 32'(slip_count), 32'd2);
        check("rot2_slip_gap", 32'(slip_gap), 32'd10);

        // Table: loss-of-alignment filter and data path
        tick();
        snap = slips_seen;
        for (int i = 0; i < 10; i++) begin
            bad = vecs[i].bad;
            data_words = vecs[i].data;
            tick();
            check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].data));
            check($sformatf("vec%0d_aligned", i), 32'(aligned), 32'(vecs[i].exp_al));
            check($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_al));
        end
        check("loss_slip_count_cleared", 32'(slip_count), 32'd0);
        check("loss_no_slips", 32'(slips_seen - snap), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 40 && !aligned; k++) tick();
        check("realign_after_loss", 32'(aligned), 32'd1);

        // Stuck-zero frame: six slips then FAIL, restart resumes search
        do_reset();
        base = 6'b000000;
        slip_base = slips_seen;
        pll_locked = 1'b1;
        for (int k = 0; k < 200 && !align_fail; k++) tick();
        check("stuck_align_fail", 32'(align_fail), 32'd1);
        check("stuck_slips", 32'(slips_seen - slip_base), 32'd6);
        check("stuck_slip_count", 32'(slip_count), 32'd6);
        snap = slips_seen;
        for (int k = 0; k < 20; k++) tick();
        check("fail_no_slips", 32'(slips_seen - snap), 32'd0);
        check("fail_held", 32'(align_fail), 32'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_slip_count", 32'(slip_count), 32'd0);
        check("restart_fail_clear", 32'(align_fail), 32'd0);
        for (int k = 0; k < 20 && !bitslip; k++) tick();
        check("restart_bitslip", 32'(bitslip), 32'd1);

        // Lock loss mid-SETTLE
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        check("lock_settle_aligned", 32'(aligned), 32'd0);
        check("lock_settle_fail", 32'(align_fail), 32'd0);
        snap = slips_seen;
        for (int k = 0; k < 20; k++) tick();
        check("lock_settle_no_slips", 32'(slips_seen - snap), 32'd0);
        check("lock_settle_slip_count", 32'(slip_count), 32'd0);

        // Re-lock, then lock loss while aligned
        base = PAT;
        slip_base = slips_seen;
        pll_locked = 1'b1;
        for (int k = 0; k < 40 && !aligned; k++) tick();
        check("relock_aligned", 32'(aligned), 32'd1);
`ifdef LVDS_FRAME_ALIGN_STATS_EN
        for (int k = 0; k < 5; k++) begin
            bad = 1'b1;
            tick();
            bad = 1'b0;
            tick();
            tick();
        end
        check("stats_err_count", 32'(err_count), 32'd5);
        check("stats_still_aligned", 32'(aligned), 32'd1);
`endif
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        check("lock_drop_aligned", 32'(aligned), 32'd0);
        check("lock_drop_valid", 32'(data_valid), 32'd0);
`ifdef LVDS_FRAME_ALIGN_STATS_EN
        tick();
        check("stats_err_cleared", 32'(err_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
